// File: rtl/cnt_ctrl_fsm_if.sv
// Button inputs and counter-control outputs of cnt_ctrl_fsm.
// master drives the raw buttons; slave is the sequencer side.
interface cnt_ctrl_fsm_if;
  logic       btn_start;
  logic       btn_stop;
  logic       btn_rst;
  logic       cnt_start;
  logic       cnt_stop;
  logic       cnt_rst;
  logic       cnt_tick;
  logic [1:0] state_out;

  modport master (
    output btn_start,
    output btn_stop,
    output btn_rst,
    input  cnt_start,
    input  cnt_stop,
    input  cnt_rst,
    input  cnt_tick,
    input  state_out
  );

  modport slave (
    input  btn_start,
    input  btn_stop,
    input  btn_rst,
    output cnt_start,
    output cnt_stop,
    output cnt_rst,
    output cnt_tick,
    output state_out
  );
endinterface

// File: rtl/cnt_ctrl_fsm.sv
// Push-button sequencer: sync + debounce, IDLE/RUN/PAUSE FSM, prescaled count tick.
// Define CNT_CTRL_TOGGLE_EN to make btn_start pause a running counter.
module cnt_ctrl_fsm #(
  parameter int unsigned DBNC_CYCLES = 4,
  parameter int unsigned PRESC_DIV   = 10,
  parameter int unsigned PRESC_BITS  = 16
) (
  input logic            clk,
  input logic            rst,
  cnt_ctrl_fsm_if.slave  bus
);

  localparam logic [1:0] StIdle  = 2'b00;
  localparam logic [1:0] StRun   = 2'b01;
  localparam logic [1:0] StPause = 2'b10;

  localparam int unsigned BtnStart = 0;
  localparam int unsigned BtnStop  = 1;
  localparam int unsigned BtnRst   = 2;

  localparam logic [7:0]            DbncLast  = 8'(DBNC_CYCLES);
  localparam logic [PRESC_BITS-1:0] PrescLast = PRESC_BITS'(PRESC_DIV - 1);

  logic [2:0]      btn_raw;
  logic [2:0]      sync1_q, sync2_q;
  logic [2:0]      db_level_q, db_level_d;
  logic [2:0][7:0] db_cnt_q, db_cnt_d;
  logic [2:0]      evt_q, evt_d;

  logic [1:0]            state_q, state_d;
  logic                  start_q, start_d;
  logic                  stop_q, stop_d;
  logic                  rstp_q, rstp_d;
  logic                  tick_q, tick_d;
  logic [PRESC_BITS-1:0] presc_q, presc_d;

  assign btn_raw = {bus.btn_rst, bus.btn_stop, bus.btn_start};

  // The flip fires on the edge that would bring the counter to DBNC_CYCLES.
  always_comb begin
    db_level_d = db_level_q;
    db_cnt_d   = '0;
    evt_d      = '0;
    for (int i = 0; i < 3; i++) begin
      if (sync2_q[i] != db_level_q[i]) begin
        if (db_cnt_q[i] + 8'd1 == DbncLast) begin
          db_level_d[i] = sync2_q[i];
          evt_d[i]      = sync2_q[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + 8'd1;
        end
      end
    end
  end

  // The highest-priority pending event decides; an ignored winner still drops the rest.
  always_comb begin
    state_d = state_q;
    start_d = 1'b0;
    stop_d  = 1'b0;
    rstp_d  = 1'b0;
    if (evt_q[BtnRst]) begin
      state_d = StIdle;
      rstp_d  = 1'b1;
    end else if (evt_q[BtnStop]) begin
      if (state_q == StRun) begin
        state_d = StPause;
        stop_d  = 1'b1;
      end
    end else if (evt_q[BtnStart]) begin
      if (state_q == StIdle || state_q == StPause) begin
        state_d = StRun;
        start_d = 1'b1;
      end
`ifdef CNT_CTRL_TOGGLE_EN
      else if (state_q == StRun) begin
        state_d = StPause;
        stop_d  = 1'b1;
      end
`endif
    end
  end

  // Count advances only while RUN was the current state, so a resume restarts from the held value.
  always_comb begin
    presc_d = presc_q;
    tick_d  = 1'b0;
    if (state_d == StIdle) begin
      presc_d = '0;
    end else if (state_q == StRun) begin
      if (presc_q == PrescLast) begin
        presc_d = '0;
        tick_d  = (state_d == StRun);
      end else begin
        presc_d = presc_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q    <= '0;
      sync2_q    <= '0;
      db_level_q <= '0;
      db_cnt_q   <= '0;
      evt_q      <= '0;
      state_q    <= StIdle;
      start_q    <= 1'b0;
      stop_q     <= 1'b0;
      rstp_q     <= 1'b0;
      tick_q     <= 1'b0;
      presc_q    <= '0;
    end else begin
      sync1_q    <= btn_raw;
      sync2_q    <= sync1_q;
      db_level_q <= db_level_d;
      db_cnt_q   <= db_cnt_d;
      evt_q      <= evt_d;
      state_q    <= state_d;
      start_q    <= start_d;
      stop_q     <= stop_d;
      rstp_q     <= rstp_d;
      tick_q     <= tick_d;
      presc_q    <= presc_d;
    end
  end

  assign bus.cnt_start = start_q;
  assign bus.cnt_stop  = stop_q;
  assign bus.cnt_rst   = rstp_q;
  assign bus.cnt_tick  = tick_q;
  assign bus.state_out = state_q;

endmodule

// File: doc/cnt_ctrl_fsm.md
Name: cnt_ctrl_fsm

Overview:
Control sequencer for the n-bit counter datapath. It takes three raw push-button inputs and synchronises and debounces each one. A RUN/PAUSE/IDLE state machine turns them into single-cycle cnt_start/cnt_stop/cnt_rst pulses for the counter. It also generates a prescaled count-enable tick while running. It sits between the pad inputs and the counter instance inside the counter top level.

Parameters:
DBNC_CYCLES, 4, consecutive stable cycles (at synchroniser output) required to accept a new button level; legal range 1..255.
PRESC_DIV, 10, tick period in clk cycles while RUN; legal range 2..65535.
PRESC_BITS, 16, width of the prescaler counter; must satisfy 2^PRESC_BITS >= PRESC_DIV.

Ports:
clk  input  1  system clock
rst  input  1  synchronous, active-high reset
btn_start  input  1  raw start button, asynchronous, active-high
btn_stop  input  1  raw stop button, asynchronous, active-high
btn_rst  input  1  raw counter-reset button, asynchronous, active-high
cnt_start  output  1  one-cycle pulse to the counter start input
cnt_stop  output  1  one-cycle pulse to the counter stop input
cnt_rst  output  1  one-cycle pulse to the counter reset input
cnt_tick  output  1  one-cycle count-enable pulse, every PRESC_DIV cycles in RUN
state_out  output  2  current state: 00 IDLE, 01 RUN, 10 PAUSE (11 never driven)

Behaviour:
- Reset (rst=1 at an edge):
  - state=IDLE.
  - All outputs 0.
  - Synchroniser flops, debounced levels, debounce counters, event flags and prescaler cleared.
  - rst overrides every other input in the same cycle.
- Synchroniser: two flops per button.
- Debounce, per button:
  - The counter increments on each edge where sync_out != db_level.
  - It clears on any edge where they are equal.
  - When the counter would reach DBNC_CYCLES, db_level flips and the counter clears.
  - A rising flip sets a registered one-cycle event flag on that same edge. Falling flips create no event.
  - A pulse at sync_out shorter than DBNC_CYCLES cycles is ignored.
- Latency: if a button is first sampled high at edge k and held, its event flag is high after edge k+DBNC_CYCLES+1. The corresponding output pulse is registered at edge k+DBNC_CYCLES+2.
- FSM (registered; output pulses are registered with the transition):
  - IDLE + start_evt -> RUN, pulse cnt_start.
  - RUN + stop_evt -> PAUSE, pulse cnt_stop.
  - PAUSE + start_evt -> RUN, pulse cnt_start.
  - Any state + rst_evt -> IDLE, pulse cnt_rst. This applies even in IDLE, so the counter is always cleared.
  - Ignored events: start_evt in RUN, stop_evt in IDLE or PAUSE.
- Simultaneous events, priority rst_evt > stop_evt > start_evt:
  - Only the winning transition happens; lower events that cycle are dropped.
  - At most one of cnt_start/cnt_stop/cnt_rst is high in any cycle.
- Prescaler:
  - RUN: counts 0..PRESC_DIV-1 and wraps to 0. cnt_tick=1 for the cycle the count equals PRESC_DIV-1.
  - PAUSE: holds its value; cnt_tick=0.
  - IDLE: cleared to 0; cnt_tick=0.
  - The first tick after IDLE->RUN comes PRESC_DIV cycles after the cnt_start pulse cycle. After PAUSE->RUN it resumes from the held count.
- rst mid-operation: takes effect at the next edge. A pending event flag is discarded and no pulse is emitted.

Optional Feature:
CNT_CTRL_TOGGLE_EN
- Defined: start_evt in RUN -> PAUSE with a cnt_stop pulse, so btn_start acts as a start/pause toggle. btn_stop still works as specified. Priority is unchanged.
- Undefined: start_evt in RUN is ignored.

Test Plan:
1. DBNC_CYCLES=4, PRESC_DIV=10. Assert rst, then release; btn_start high from edge 0 -> cnt_start pulse registered at edge 6 for exactly 1 cycle; state_out=01; first cnt_tick 10 cycles later, then every 10 cycles.
2. btn_start glitch high for 3 cycles -> no cnt_start and state stays IDLE. Then held 5+ cycles -> cnt_start pulse.
3. In RUN at prescaler count 4, press btn_stop -> cnt_stop pulse; state 10; no ticks. Then btn_start -> cnt_start pulse; next tick 5 cycles after resume.
4. btn_start, btn_stop and btn_rst rise in the same cycle while in RUN -> only cnt_rst pulses; state 00; prescaler 0.
5. rst asserted one cycle before an expected cnt_start pulse -> no pulse; all outputs 0; state 00.
6. With CNT_CTRL_TOGGLE_EN defined: btn_start press in RUN -> cnt_stop pulse and state 10. Without it: the same stimulus leaves state 01 and emits no pulse.
